// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MULT/MULTU by shift-add, DIV/DIVU by
// restoring division, one step per cycle, results held in HI/LO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op, a, b   issue request: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   cancel            abort an in-flight operation
//   busy, done        busy during CALC/FIX; done pulses one cycle
//   div_by_zero       with done: the divide had b == 0
//   hi, lo            product halves, or remainder / quotient
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic                 neg_a_q, neg_a_d;
   logic                 neg_b_q, neg_b_d;
   logic [WIDTH-1:0]     a_q, a_d;
   // multiplicand for multiply, divisor magnitude for divide
   logic [WIDTH-1:0]     m_q, m_d;
   // multiply: {partial product, multiplier}
   // divide:   {partial remainder, dividend / quotient bits}
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 dbz_q, dbz_d;

   logic                 in_sgn;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [WIDTH:0]       msum;
   logic [2*WIDTH-1:0]   mul_nxt;
   logic [WIDTH:0]       dsh;
   logic [WIDTH:0]       ddif;
   logic [2*WIDTH-1:0]   div_nxt;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo_s;
   logic [WIDTH-1:0]     rem_s;

   assign in_sgn = ~op[0];
   assign abs_a  = (in_sgn && a[WIDTH-1]) ? -a : a;
   assign abs_b  = (in_sgn && b[WIDTH-1]) ? -b : b;

   // shift-add: add multiplicand when the multiplier LSB is set,
   // then shift the whole accumulator right by one
   assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
   assign mul_nxt = {msum, acc_q[WIDTH-1:1]};

   // restoring step: remainder is always below the divisor, so the
   // top bit of the (W+1)-bit difference is a clean borrow flag
   assign dsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign ddif    = dsh - {1'b0, m_q};
   assign div_nxt = ddif[WIDTH]
                  ? {dsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {ddif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   // (-2^(W-1)) / -1 falls out naturally: magnitude quotient 2^(W-1)
   // with positive sign already reads back as 0x80..0
   assign prod_s = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
   assign quo    = acc_q[WIDTH-1:0];
   assign rem    = acc_q[2*WIDTH-1:WIDTH];
   assign quo_s  = (neg_a_q ^ neg_b_q) ? -quo : quo;
   assign rem_s  = neg_a_q ? -rem : rem;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      a_d     = a_q;
      m_d     = m_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start && !cancel) begin
               state_d = S_CALC;
               cnt_d   = '0;
               op_d    = op;
               neg_a_d = in_sgn & a[WIDTH-1];
               neg_b_d = in_sgn & b[WIDTH-1];
               a_d     = a;
               if (op[1]) begin
                  m_d   = abs_b;
                  acc_d = {{WIDTH{1'b0}}, abs_a};
               end else begin
                  m_d   = abs_a;
                  acc_d = {{WIDTH{1'b0}}, abs_b};
               end
            end
         end
         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[1] ? div_nxt : mul_nxt;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               dbz_d   = 1'b0;
               if (!op_q[1]) begin
                  hi_d = prod_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_s[WIDTH-1:0];
               end else if (m_q == '0) begin
                  hi_d  = a_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem_s;
                  lo_d = quo_s;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         a_q     <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         a_q     <= a_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = done & dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
